food_spawner: RTL

- Consumes the free-running 8-bit pseudo-random byte and turns it into an in-bounds, unoccupied grid cell for placing a new food item.
- Sits between the pseudo-random generator (upstream) and the game-state logic. Game-state logic requests a spawn, answers occupancy queries, and latches the result.
- Uses rejection sampling first. After MAX_TRIES rejections it falls back to a deterministic linear scan, so it always terminates.

---
 rtl/food_spawner_pkg.sv | 30 +++
 rtl/food_spawner_cell_scan_counter.sv | 53 +++++
 rtl/food_spawner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/food_spawner_pkg.sv
// Shared game constants and cell types for the food spawner and its scan counter.
// next_cell() walks the grid in raster order, wrapping x into y and y back to row 0.
package food_spawner_pkg;

  localparam int unsigned GRID_W = 16;
  localparam int unsigned GRID_H = 12;
  localparam int unsigned X_W    = 4;
  localparam int unsigned Y_W    = 4;

  typedef logic [X_W-1:0] cell_x_t;
  typedef logic [Y_W-1:0] cell_y_t;

  typedef struct packed {
    cell_x_t x;
    cell_y_t y;
  } cell_t;

  function automatic cell_t next_cell(input cell_t c);
    cell_t n;
    n = c;
    if (32'(c.x) == GRID_W - 1) begin
      n.x = '0;
      n.y = (32'(c.y) == GRID_H - 1) ? '0 : c.y + 1'b1;
    end else begin
      n.x = c.x + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/food_spawner_cell_scan_counter.sv
// Linear grid walker for the fallback scan: loads a start cell, steps in raster order
// with wrap, and flags o_done once every cell of the grid has been stepped over.
module food_spawner_cell_scan_counter
  import food_spawner_pkg::*;
(
  input  logic           clk,
  input  logic           arst,
  input  logic           i_load,
  input  logic           i_load_next,
  input  logic [X_W-1:0] i_start_x,
  input  logic [Y_W-1:0] i_start_y,
  input  logic           i_step,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_done
);

  localparam int unsigned Cells = GRID_W * GRID_H;
  localparam int unsigned CntW  = $clog2(Cells + 1);

  cell_t            start;
  cell_t            cur_q, cur_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    start.x = i_start_x;
    start.y = i_start_y;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    if (i_load) begin
      cur_d = i_load_next ? next_cell(start) : start;
      cnt_d = '0;
    end else if (i_step) begin
      cur_d = next_cell(cur_q);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cur_q <= '0;
      cnt_q <= '0;
    end else begin
      cur_q <= cur_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_x    = cur_q.x;
  assign o_y    = cur_q.y;
  assign o_done = (32'(cnt_q) == Cells);

endmodule

// File: rtl/food_spawner.sv
// Picks a free, in-bounds grid cell for new food: rejection sampling on the PRNG byte,
// then a deterministic raster scan once MAX_TRIES candidates have been rejected.
module food_spawner
  import food_spawner_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 32
) (
  input  logic           clk,
  input  logic           arst,
  input  logic [7:0]     i_prng,
  input  logic           i_spawn_req,
  output logic           o_busy,
  output logic [X_W-1:0] o_occ_x,
  output logic [Y_W-1:0] o_occ_y,
  output logic           o_occ_vld,
  input  logic           i_occ,
  output logic           o_valid,
  output logic           o_fail,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y
);

  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSample  = 3'd1;
  localparam logic [2:0] StCheck   = 3'd2;
  localparam logic [2:0] StScan    = 3'd3;
  localparam logic [2:0] StScanChk = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [TryW-1:0] tries_q, tries_d, tries_inc;
  cell_t           cand_q, cand_d;
  logic            have_cand_q, have_cand_d;
  cell_t           res_q, res_d;
  logic            valid_q, valid_d;
  logic            fail_q, fail_d;

  cell_t prng_cell, occ_cell, scan_start, scan_cell;
  logic  x_ok, y_ok, in_range, last_try;
  logic  occ_vld, scan_load, scan_load_next, scan_step, scan_done;

  assign prng_cell.x = i_prng[X_W-1:0];
  assign prng_cell.y = i_prng[7 -: Y_W];

  // A grid that fills the coordinate space accepts every candidate on that axis.
  if (GRID_W == 2 ** X_W) begin : g_x_full
    assign x_ok = 1'b1;
  end else begin : g_x_part
    assign x_ok = (32'(prng_cell.x) < GRID_W);
  end
  if (GRID_H == 2 ** Y_W) begin : g_y_full
    assign y_ok = 1'b1;
  end else begin : g_y_part
    assign y_ok = (32'(prng_cell.y) < GRID_H);
  end

  assign in_range  = x_ok & y_ok;
  assign tries_inc = tries_q + 1'b1;
  assign last_try  = (32'(tries_inc) == MAX_TRIES);

  always_comb begin
    state_d        = state_q;
    tries_d        = tries_q;
    cand_d         = cand_q;
    have_cand_d    = have_cand_q;
    res_d          = res_q;
    valid_d        = 1'b0;
    fail_d         = 1'b0;
    occ_vld        = 1'b0;
    occ_cell       = '0;
    scan_load      = 1'b0;
    scan_load_next = 1'b0;
    scan_start     = cand_q;
    scan_step      = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_spawn_req) begin
          state_d     = StSample;
          tries_d     = '0;
          have_cand_d = 1'b0;
        end
      end
      StSample: begin
        if (in_range) begin
          occ_vld     = 1'b1;
          occ_cell    = prng_cell;
          cand_d      = prng_cell;
          have_cand_d = 1'b1;
          state_d     = StCheck;
        end else begin
          tries_d = tries_inc;
          if (last_try) begin
            scan_load  = 1'b1;
            scan_start = have_cand_q ? cand_q : '0;
            state_d    = StScan;
          end
        end
      end
      StCheck: begin
        if (!i_occ) begin
          res_d   = cand_q;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          tries_d = tries_inc;
          if (last_try) begin
            scan_load      = 1'b1;
            scan_load_next = 1'b1;
            state_d        = StScan;
          end else begin
            state_d = StSample;
          end
        end
      end
      StScan: begin
        if (scan_done) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end else begin
          occ_vld  = 1'b1;
          occ_cell = scan_cell;
          state_d  = StScanChk;
        end
      end
      StScanChk: begin
        if (!i_occ) begin
          res_d   = scan_cell;
          valid_d = 1'b1;
          state_d = StIdle;
        end else begin
          scan_step = 1'b1;
          state_d   = StScan;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= StIdle;
      tries_q     <= '0;
      cand_q      <= '0;
      have_cand_q <= 1'b0;
      res_q       <= '0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      cand_q      <= cand_d;
      have_cand_q <= have_cand_d;
      res_q       <= res_d;
      valid_q     <= valid_d;
      fail_q      <= fail_d;
    end
  end

  food_spawner_cell_scan_counter u_scan (
    .clk         (clk),
    .arst        (arst),
    .i_load      (scan_load),
    .i_load_next (scan_load_next),
    .i_start_x   (scan_start.x),
    .i_start_y   (scan_start.y),
    .i_step      (scan_step),
    .o_x         (scan_cell.x),
    .o_y         (scan_cell.y),
    .o_done      (scan_done)
  );

  // The result pulse lands after the FSM is already back in idle; busy covers that cycle.
  assign o_busy    = (state_q != StIdle) | valid_q | fail_q;
  assign o_occ_x   = occ_cell.x;
  assign o_occ_y   = occ_cell.y;
  assign o_occ_vld = occ_vld;
  assign o_valid   = valid_q;
  assign o_fail    = fail_q;
  assign o_x       = res_q.x;
  assign o_y       = res_q.y;

endmodule
